// File: rtl/step_dec_seq.sv
// Registered step sequencer (IDLE/RUN) with enable-gated one-hot decode of the step.
// Optional STEP_DEC_SEQ_WRAP_EN: terminal advance wraps to 0 and stays in RUN.
module step_dec_seq #(
  parameter int N    = 3,
  parameter int LAST = (1 << N) - 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic              advance_i,
  input  logic              load_i,
  input  logic [N-1:0]      w_i,
  output logic [2**N-1:0]   y_o,
  output logic [N-1:0]      step_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [N-1:0] LAST_V = N'(LAST);

  state_e         state_q, state_d;
  logic [N-1:0]   step_q, step_d;
  logic           done_q, done_d;
  logic [N-1:0]   wc;

  assign wc = (w_i > LAST_V) ? LAST_V : w_i;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      step_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_i) begin
            state_d = RUN;
            step_d  = load_i ? wc : '0;
          end else if (load_i) begin
            step_d = wc;
          end
        end
        RUN: begin
          // Load outranks Advance in the same cycle.
          if (load_i) begin
            step_d = wc;
          end else if (advance_i) begin
            if (step_q == LAST_V) begin
              step_d = '0;
              done_d = 1'b1;
`ifdef STEP_DEC_SEQ_WRAP_EN
              state_d = RUN;
`else
              state_d = IDLE;
`endif
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    y_o         = '0;
    y_o[step_q] = en_i;
  end

  assign step_o = step_q;
  assign busy_o = (state_q == RUN);
  assign done_o = done_q;

endmodule

// File: tb/tb_step_dec_seq.sv
// Bench for step_dec_seq: three instances (LAST=7,5,0) share stimulus; a rule-level
// model per instance predicts Step/Busy/Done/Y after directed and random cycles.
module tb_step_dec_seq;

  logic       Clock = 1'b0;
  logic       Reset, en, clr, run, adv, load;
  logic [2:0] w;
  logic [7:0] y   [3];
  logic [2:0] st  [3];
  logic       bz  [3];
  logic       dn  [3];

  int n_cmp = 0;
  int n_bad = 0;

  int m_step [3];
  bit m_busy [3];
  bit m_done [3];
  int lastv  [3] = '{7, 5, 0};

`ifdef STEP_DEC_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  always #5 Clock = ~Clock;

  step_dec_seq #(.N(3))            u7 (.Clock(Clock), .Reset(Reset), .en_i(en), .clear_i(clr),
    .run_i(run), .advance_i(adv), .load_i(load), .w_i(w), .y_o(y[0]), .step_o(st[0]),
    .busy_o(bz[0]), .done_o(dn[0]));
  step_dec_seq #(.N(3), .LAST(5))  u5 (.Clock(Clock), .Reset(Reset), .en_i(en), .clear_i(clr),
    .run_i(run), .advance_i(adv), .load_i(load), .w_i(w), .y_o(y[1]), .step_o(st[1]),
    .busy_o(bz[1]), .done_o(dn[1]));
  step_dec_seq #(.N(3), .LAST(0))  u0 (.Clock(Clock), .Reset(Reset), .en_i(en), .clear_i(clr),
    .run_i(run), .advance_i(adv), .load_i(load), .w_i(w), .y_o(y[2]), .step_o(st[2]),
    .busy_o(bz[2]), .done_o(dn[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply the priority rules to the model of each instance.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int wc;
      wc = (int'(w) > lastv[k]) ? lastv[k] : int'(w);
      if (Reset || clr) begin
        m_step[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      end else begin
        m_done[k] = 0;
        if (!m_busy[k] && run) begin
          m_busy[k] = 1;
          m_step[k] = load ? wc : 0;
        end else if (load) begin
          m_step[k] = wc;
        end else if (m_busy[k] && adv) begin
          if (m_step[k] == lastv[k]) begin
            m_step[k] = 0;
            m_done[k] = 1;
            m_busy[k] = WRAP;
          end else begin
            m_step[k] = m_step[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic check_y();
    for (int k = 0; k < 3; k++)
      chk($sformatf("y[L%0d]", lastv[k]), 32'(y[k]), en ? (32'd1 << m_step[k]) : 32'd0);
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("step[L%0d]", lastv[k]), 32'(st[k]), 32'(m_step[k]));
      chk($sformatf("busy[L%0d]", lastv[k]), 32'(bz[k]), 32'(m_busy[k]));
      chk($sformatf("done[L%0d]", lastv[k]), 32'(dn[k]), 32'(m_done[k]));
    end
    check_y();
  endtask

  task automatic cyc(input bit r, input bit c, input bit ru, input bit a, input bit l,
                     input logic [2:0] wv);
    Reset = r; clr = c; run = ru; adv = a; load = l; w = wv;
    @(posedge Clock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    Reset = 1; en = 1; clr = 0; run = 0; adv = 0; load = 0; w = '0;
    foreach (m_step[k]) begin m_step[k] = 0; m_busy[k] = 0; m_done[k] = 0; end

    // Reset held two cycles, then literal reset values.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_y7", 32'(y[0]), 32'h01);
    chk("reset_busy7", 32'(bz[0]), 32'd0);
    en = 0; #1;
    chk("en_off_y7", 32'(y[0]), 32'h00);
    check_y();
    en = 1; #1;

    // Full sequence: Run then six Advances.
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("seq_done5", 32'(dn[1]), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("seq_done5_drop", 32'(dn[1]), 32'd0);

    // Load and clamp.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 3);
    chk("load_y5", 32'(y[1]), 32'h08);
    cyc(0, 0, 0, 0, 1, 7);
    chk("clamp_y5", 32'(y[1]), 32'h20);
    cyc(0, 0, 0, 1, 1, 2);
    chk("load_wins5", 32'(st[1]), 32'd2);

    // Abort with Clear+Advance at step 4, then Reset on a Done cycle.
    cyc(0, 0, 0, 0, 1, 4);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 5);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Ignored inputs: Advance in IDLE, Run in RUN.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    // Run coincident with a terminal advance.
    cyc(0, 0, 0, 1, 1, 5);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 30) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0, 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
